// File: rtl/sasanqua_axi_lite_master.sv
// sasanqua_axi_lite_master: single-outstanding command-to-AXI4-Lite bridge with a held response stage.
module sasanqua_axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            REQ_VALID,
  output logic                            REQ_READY,
  input  logic                            REQ_WRITE,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] REQ_WSTRB,
  output logic                            RESP_VALID,
  input  logic                            RESP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RESP_RDATA,
  output logic                            RESP_ERR,
  output logic [31:0]                     TXN_CNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, RESP} state_t;
  state_t state, state_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata, rdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic aw_done, w_done, err;
  logic [31:0] cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (REQ_VALID && REQ_READY) begin
        addr <= REQ_ADDR;
        wdata <= REQ_WDATA;
        wstrb <= REQ_WSTRB;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
      if (M_AXI_WVALID && M_AXI_WREADY) w_done <= 1'b1;
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        rdata <= '0;
        err <= |M_AXI_BRESP;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        rdata <= M_AXI_RDATA;
        err <= |M_AXI_RRESP;
      end
      if (RESP_VALID && RESP_READY) cnt <= cnt + 32'd1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = REQ_VALID ? (REQ_WRITE ? WR : RD) : IDLE;
      WR:      state_n = ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) ? WAIT_B : WR;
      WAIT_B:  state_n = M_AXI_BVALID ? RESP : WAIT_B;
      RD:      state_n = M_AXI_ARREADY ? WAIT_R : RD;
      WAIT_R:  state_n = M_AXI_RVALID ? RESP : WAIT_R;
      RESP:    state_n = RESP_READY ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    REQ_READY = state == IDLE;
    M_AXI_AWVALID = state == WR && !aw_done;
    M_AXI_WVALID = state == WR && !w_done;
    M_AXI_BREADY = state == WAIT_B;
    M_AXI_ARVALID = state == RD;
    M_AXI_RREADY = state == WAIT_R;
    RESP_VALID = state == RESP;
    RESP_RDATA = rdata;
    RESP_ERR = err;
    TXN_CNT = cnt;
    M_AXI_AWADDR = addr;
    M_AXI_ARADDR = addr;
    M_AXI_WDATA = wdata;
    M_AXI_WSTRB = wstrb;
    M_AXI_AWPROT = 3'b000;
    M_AXI_ARPROT = 3'b000;
  end
endmodule

// File: tb/tb_sasanqua_axi_lite_master.sv
// tb_sasanqua_axi_lite_master: memory-backed slave and word-memory reference model driving random and directed transactions.
module tb_sasanqua_axi_lite_master;
  localparam int AW = 16;
  logic CLK = 1'b0, RST = 1'b1;
  logic REQ_VALID, REQ_READY, REQ_WRITE, RESP_VALID, RESP_READY, RESP_ERR;
  logic [AW-1:0] REQ_ADDR, M_AXI_AWADDR, M_AXI_ARADDR;
  logic [31:0] REQ_WDATA, RESP_RDATA, TXN_CNT, M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0] REQ_WSTRB, M_AXI_WSTRB;
  logic [2:0] M_AXI_AWPROT, M_AXI_ARPROT;
  logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BREADY;
  logic M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RREADY;
  logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
  int errors = 0, checks = 0;
  logic [31:0] model_mem [16];
  logic [31:0] slave_mem [16];
  logic [31:0] exp_cnt = 0;

  always #5 CLK = ~CLK;

  sasanqua_axi_lite_master #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_WSTRB(REQ_WSTRB), .RESP_VALID(RESP_VALID),
    .RESP_READY(RESP_READY), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR), .TXN_CNT(TXN_CNT),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i+:8] = n[8*i+:8];
    return o;
  endfunction

  // d1: AW/AR ready delay, d2: W ready delay, d3: B/R valid delay, d4: RESP_READY delay
  task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int d1, input int d2, input int d3, input int d4, input logic [1:0] rc,
                        input logic stray);
    logic [31:0] er, rdat, sd;
    logic [AW-1:0] sa;
    logic [3:0] ss;
    logic e1, e2;
    int k;
    er = w ? 32'h0 : model_mem[a[5:2]];
    rdat = 32'h0; sd = 32'h0; sa = '0; ss = 4'h0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL req_ready_idle got=%b exp=1", REQ_READY); end
    REQ_VALID = 1'b1; REQ_WRITE = w; REQ_ADDR = a; REQ_WDATA = d; REQ_WSTRB = s;
    @(negedge CLK);
    REQ_VALID = 1'b0; REQ_ADDR = AW'($urandom); REQ_WDATA = $urandom; REQ_WSTRB = 4'($urandom);
    e1 = 1'b0; e2 = !w; k = 0;
    while (!(e1 && e2) && k < 40) begin
      if (w) begin
        checks++; if (M_AXI_AWVALID !== !e1) begin errors++; $display("FAIL awvalid k=%0d got=%b exp=%b", k, M_AXI_AWVALID, !e1); end
        checks++; if (M_AXI_WVALID !== !e2) begin errors++; $display("FAIL wvalid k=%0d got=%b exp=%b", k, M_AXI_WVALID, !e2); end
        checks++; if (M_AXI_BREADY !== 1'b0) begin errors++; $display("FAIL bready_early got=%b exp=0", M_AXI_BREADY); end
        if (!e1) begin checks++; if (M_AXI_AWADDR !== a) begin errors++; $display("FAIL awaddr got=%h exp=%h", M_AXI_AWADDR, a); end end
        if (!e2) begin checks++; if (M_AXI_WDATA !== d || M_AXI_WSTRB !== s) begin errors++; $display("FAIL wdata got=%h/%h exp=%h/%h", M_AXI_WDATA, M_AXI_WSTRB, d, s); end end
      end else begin
        checks++; if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== a) begin errors++; $display("FAIL arvalid got=%b/%h exp=1/%h", M_AXI_ARVALID, M_AXI_ARADDR, a); end
        checks++; if (M_AXI_RREADY !== 1'b0 || M_AXI_AWVALID !== 1'b0) begin errors++; $display("FAIL rd_phase got rready=%b awvalid=%b exp=0", M_AXI_RREADY, M_AXI_AWVALID); end
      end
      checks++; if (M_AXI_AWPROT !== 3'b000 || M_AXI_ARPROT !== 3'b000) begin errors++; $display("FAIL prot got=%b/%b exp=000", M_AXI_AWPROT, M_AXI_ARPROT); end
      M_AXI_AWREADY = w && !e1 && k == d1;
      M_AXI_WREADY = w && !e2 && k == d2;
      M_AXI_ARREADY = !w && k == d1;
      M_AXI_BVALID = !w && stray; M_AXI_BRESP = 2'($urandom);
      M_AXI_RVALID = w && stray; M_AXI_RRESP = 2'($urandom); M_AXI_RDATA = $urandom;
      if (M_AXI_AWREADY) sa = M_AXI_AWADDR;
      if (M_AXI_WREADY) begin sd = M_AXI_WDATA; ss = M_AXI_WSTRB; end
      if (M_AXI_ARREADY) rdat = slave_mem[M_AXI_ARADDR[5:2]];
      @(negedge CLK);
      if (M_AXI_AWREADY || M_AXI_ARREADY) e1 = 1'b1;
      if (M_AXI_WREADY) e2 = 1'b1;
      k++;
    end
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
    checks++; if (!(e1 && e2)) begin errors++; $display("FAIL addr_phase_timeout got=%b%b exp=11", e1, e2); end
    if (w) slave_mem[sa[5:2]] = merge(slave_mem[sa[5:2]], sd, ss);
    for (int j = 0; j <= d3; j++) begin
      checks++; if (M_AXI_BREADY !== w || M_AXI_RREADY !== !w) begin errors++; $display("FAIL resp_ready j=%0d got=%b/%b exp=%b/%b", j, M_AXI_BREADY, M_AXI_RREADY, w, !w); end
      checks++; if (M_AXI_AWVALID !== 1'b0 || M_AXI_WVALID !== 1'b0 || M_AXI_ARVALID !== 1'b0 || RESP_VALID !== 1'b0) begin errors++; $display("FAIL wait_valids got=%b%b%b%b exp=0000", M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, RESP_VALID); end
      if (w) begin M_AXI_BVALID = j == d3; M_AXI_BRESP = rc; M_AXI_RVALID = stray; M_AXI_RDATA = $urandom; end
      else begin M_AXI_RVALID = j == d3; M_AXI_RRESP = rc; M_AXI_RDATA = rdat; end
      @(negedge CLK);
    end
    M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = $urandom; M_AXI_RRESP = 2'($urandom); M_AXI_BRESP = 2'($urandom);
    for (int j = 0; j <= d4; j++) begin
      checks++; if (RESP_VALID !== 1'b1) begin errors++; $display("FAIL resp_valid j=%0d got=%b exp=1", j, RESP_VALID); end
      checks++; if (RESP_RDATA !== er || RESP_ERR !== (rc != 2'b00)) begin errors++; $display("FAIL resp_data got=%h/%b exp=%h/%b", RESP_RDATA, RESP_ERR, er, rc != 2'b00); end
      checks++; if (REQ_READY !== 1'b0 || M_AXI_BREADY !== 1'b0 || M_AXI_RREADY !== 1'b0) begin errors++; $display("FAIL resp_ready_outs got=%b%b%b exp=000", REQ_READY, M_AXI_BREADY, M_AXI_RREADY); end
      RESP_READY = j == d4;
      if (stray) begin REQ_VALID = 1'b1; REQ_WRITE = 1'($urandom); end
      @(negedge CLK);
    end
    RESP_READY = 1'b0; REQ_VALID = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    if (w) model_mem[a[5:2]] = merge(model_mem[a[5:2]], d, s);
    checks++; if (RESP_VALID !== 1'b0 || REQ_READY !== 1'b1) begin errors++; $display("FAIL return_idle got=%b/%b exp=0/1", RESP_VALID, REQ_READY); end
    checks++; if (TXN_CNT !== exp_cnt) begin errors++; $display("FAIL txn_cnt got=%h exp=%h", TXN_CNT, exp_cnt); end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RESP_VALID} !== 6'b0) begin errors++; $display("FAIL reset_valids got=%b exp=0", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RESP_VALID}); end
    checks++; if (RESP_RDATA !== 32'h0 || RESP_ERR !== 1'b0 || TXN_CNT !== 32'h0) begin errors++; $display("FAIL reset_regs got=%h/%b/%h exp=0", RESP_RDATA, RESP_ERR, TXN_CNT); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", REQ_READY); end
    exp_cnt = 0;
  endtask

  task automatic test_write_basic();
    do_txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic test_aw_delay();
    do_txn(1'b1, 16'h0020, 32'hA5A5_0F0F, 4'h5, 5, 0, 1, 0, 2'b00, 1'b0);
    do_txn(1'b1, 16'h0024, 32'h1122_3344, 4'hF, 0, 3, 0, 0, 2'b01, 1'b0);
  endtask

  task automatic test_read_err();
    do_txn(1'b1, 16'h0004, 32'h12345678, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0);
    do_txn(1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 0, 0, 2'b10, 1'b0);
    do_txn(1'b0, 16'h0020, 32'h0, 4'h0, 2, 0, 2, 0, 2'b00, 1'b1);
  endtask

  task automatic test_resp_backpressure();
    do_txn(1'b0, 16'h0010, 32'h0, 4'h0, 0, 0, 0, 4, 2'b00, 1'b1);
    do_txn(1'b1, 16'h0030, 32'hCAFE_F00D, 4'hC, 1, 1, 0, 4, 2'b11, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_txn(1'($urandom), AW'($urandom & 32'hFFFC), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             2'($urandom_range(0, 3)), 1'($urandom));
  endtask

  task automatic test_reset_wait_r();
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 16'h0008;
    @(negedge CLK);
    REQ_VALID = 1'b0; M_AXI_ARREADY = 1'b1;
    @(negedge CLK);
    M_AXI_ARREADY = 1'b0;
    checks++; if (M_AXI_RREADY !== 1'b1) begin errors++; $display("FAIL wait_r_rready got=%b exp=1", M_AXI_RREADY); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RESP_VALID} !== 6'b0) begin errors++; $display("FAIL rst_mid_valids got=%b exp=0", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, RESP_VALID}); end
    checks++; if (REQ_READY !== 1'b1 || TXN_CNT !== 32'h0) begin errors++; $display("FAIL rst_mid_state got=%b/%h exp=1/0", REQ_READY, TXN_CNT); end
    exp_cnt = 0;
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge CLK);
      checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp got=%b exp=0", RESP_VALID); end
    end
    M_AXI_RVALID = 1'b0;
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut.cnt = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.cnt;
    @(negedge CLK);
    exp_cnt = 32'hFFFF_FFFF;
    checks++; if (TXN_CNT !== exp_cnt) begin errors++; $display("FAIL preload got=%h exp=%h", TXN_CNT, exp_cnt); end
    do_txn(1'b1, 16'h0000, 32'h0BAD_0BAD, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin model_mem[i] = 32'h0; slave_mem[i] = 32'h0; end
    REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = 32'h0; REQ_WSTRB = 4'h0; RESP_READY = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
    test_reset();
    test_write_basic();
    test_aw_delay();
    test_read_err();
    test_resp_backpressure();
    test_random();
    test_reset_wait_r();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
